mbist_march_ctrl: RTL

MBIST_MARCH_CTRL -- requirements
Module: mbist_march_ctrl

---
 rtl/mbist_march_ctrl.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mbist_march_ctrl.sv
// ---------------------------------------------------------------------------
// MbistMarchCtrl -- March C- memory built-in self-test controller
//
// Runs the six-element March C- sequence over a 2^ADDR_W x DATA_W memory:
//   M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0);
//   M5 up(r0)
// Writes take one cycle. Reads take two: RD (strobe) then CMP (compare).
// A miscompare parks the controller in a valid/ready handshake that offers
// the failing address to a downstream repair stage. The test resumes at the
// operation after the failing compare once the record is accepted.
//
// Ports
//   clk, rst     : single clock, synchronous active-high reset
//   start        : level, accepted only in IDLE or DONE
//   mem_we       : write strobe to the memory under test
//   mem_re       : read strobe, mem_rdata is valid the following cycle
//   mem_addr     : memory address
//   mem_wdata    : write data (all-0s or all-1s background)
//   mem_rdata    : read data returned by the memory under test
//   fail_valid   : fault record offered to the repair stage
//   fail_addr    : faulty address, stable while fail_valid is high
//   fail_ready   : repair stage accepts the record when high with fail_valid
//   busy         : test in progress, including handshake stalls
//   done         : test finished, held until the next accepted start
//   fail         : sticky, at least one miscompare in this/last test
//   fail_cnt     : miscompare count, saturating at 15
// ---------------------------------------------------------------------------
module mbist_march_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fail_valid,
  output logic [ADDR_W-1:0] fail_addr,
  input  logic              fail_ready,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [3:0]        fail_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FAIL_HS,
    DONE
  } state_t;

  // Position inside the march: element, address, operation within the
  // element (0 = first, 1 = second) and read phase (0 = RD, 1 = CMP).
  typedef struct packed {
    logic [2:0]        elem;
    logic [ADDR_W-1:0] addr;
    logic              opi;
    logic              ph;
  } pos_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [2:0]        ELEM_LAST = 3'd5;
  // Element index past M5; only reached when the final compare fails and
  // the controller must finish the handshake before going to DONE.
  localparam logic [2:0]        ELEM_END = 3'd6;

  state_t state;
  pos_t   pos;
  pos_t   pos_next;
  pos_t   load_pos;

  logic              cur_read;
  logic              cur_cmp;
  logic              cur_val;
  logic              cur_down;
  logic              op_done;
  logic              last_addr;
  logic              last_op;
  logic              mismatch;
  logic              load_read;
  logic              load_we;
  logic              load_re;
  logic [DATA_W-1:0] load_wdata;

  // Element 0 only writes, element 5 only reads; elements 1-4 read first
  // and then write.
  function automatic logic is_read(input logic [2:0] e, input logic o);
    case (e)
      3'd0:    return 1'b0;
      3'd5:    return 1'b1;
      default: return ~o;
    endcase
  endfunction

  // Data value (expected for reads, written for writes) of an operation.
  function automatic logic op_val(input logic [2:0] e, input logic o);
    case (e)
      3'd1, 3'd3: return o;
      3'd2, 3'd4: return ~o;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic two_ops(input logic [2:0] e);
    return (e >= 3'd1) && (e <= 3'd4);
  endfunction

  function automatic logic is_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  // Decode the operation currently executing and work out where the march
  // goes next. An element ends on its last address without wrapping; the
  // following element starts at its own first address.
  always_comb begin
    cur_read  = is_read(pos.elem, pos.opi);
    cur_cmp   = cur_read & pos.ph;
    cur_val   = op_val(pos.elem, pos.opi);
    cur_down  = is_down(pos.elem);
    op_done   = ~cur_read | pos.ph;
    last_addr = cur_down ? (pos.addr == '0) : (pos.addr == ADDR_MAX);
    last_op   = op_done && last_addr && (pos.elem == ELEM_LAST);
    mismatch  = cur_cmp && (mem_rdata != {DATA_W{cur_val}});

    pos_next = pos;
    if (!op_done) begin
      pos_next.ph = 1'b1;
    end else begin
      pos_next.ph = 1'b0;
      if (two_ops(pos.elem) && !pos.opi) begin
        pos_next.opi = 1'b1;
      end else begin
        pos_next.opi = 1'b0;
        if (last_addr) begin
          pos_next.elem = pos.elem + 3'd1;
          pos_next.addr = is_down(pos.elem + 3'd1) ? ADDR_MAX : '0;
        end else begin
          pos_next.addr = cur_down ? (pos.addr - ADDR_ONE) : (pos.addr + ADDR_ONE);
        end
      end
    end
  end

  // Memory strobes are registered, so they are computed from the position
  // the controller is about to execute. After a handshake that position was
  // already advanced past the failing compare and is simply replayed.
  always_comb begin
    load_pos   = (state == FAIL_HS) ? pos : pos_next;
    load_read  = is_read(load_pos.elem, load_pos.opi);
    load_we    = ~load_read;
    load_re    = load_read & ~load_pos.ph;
    load_wdata = {DATA_W{op_val(load_pos.elem, load_pos.opi)}};
  end

  // Main controller FSM. Every output is a register updated here. Reset
  // wins over everything and drops any pending fault record unaccepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pos        <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      fail_valid <= 1'b0;
      fail_addr  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      fail_cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // First operation is M0 w0 at address 0.
            state      <= RUN;
            pos        <= '0;
            mem_we     <= 1'b1;
            mem_re     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            fail_valid <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            fail       <= 1'b0;
            fail_cnt   <= 4'd0;
          end
        end

        RUN: begin
          if (mismatch) begin
            state      <= FAIL_HS;
            pos        <= pos_next;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            fail_valid <= 1'b1;
            fail_addr  <= pos.addr;
            fail       <= 1'b1;
            if (fail_cnt != 4'hF) begin
              fail_cnt <= fail_cnt + 4'd1;
            end
          end else if (last_op) begin
            state  <= DONE;
            mem_we <= 1'b0;
            mem_re <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else begin
            pos       <= pos_next;
            mem_we    <= load_we;
            mem_re    <= load_re;
            mem_addr  <= load_pos.addr;
            mem_wdata <= load_wdata;
          end
        end

        FAIL_HS: begin
          if (fail_ready) begin
            fail_valid <= 1'b0;
            if (pos.elem == ELEM_END) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= RUN;
              mem_we    <= load_we;
              mem_re    <= load_re;
              mem_addr  <= load_pos.addr;
              mem_wdata <= load_wdata;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
